// File: rtl/clock_config_sequencer_pkg.sv
// rtl/clock_config_sequencer_pkg.sv - state encoding, default waits and dwell helper for the clock sequencer
package clock_config_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_PARK    = 3'd2,
        ST_PLLON   = 3'd3,
        ST_APPLY   = 3'd4,
        ST_SELECT  = 3'd5,
        ST_RELEASE = 3'd6
    } state_t;

    localparam int DEF_RST_HOLD   = 4;
    localparam int DEF_SYNC_WAIT  = 8;
    localparam int DEF_PLL_SETTLE = 256;
    localparam int DEF_CNT_W      = 16;

    // A wait of N occupies max(N,1) cycles, so the counter starts at max(N,1)-1.
    function automatic int dwell_load(input int n);
        return (n < 1) ? 0 : n - 1;
    endfunction

endpackage

// File: rtl/clock_config_sequencer_timer.sv
// rtl/clock_config_sequencer_timer.sv - loadable down-counter shared by every dwell state
module clock_config_sequencer_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero
);

    logic [CNT_W-1:0] value;

    // Load on state entry, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/clock_config_sequencer.sv
// rtl/clock_config_sequencer.sv - parks the core on the pad clock, starts the PLL, applies dividers, selects source
module clock_config_sequencer
    import clock_config_sequencer_pkg::*;
#(
    parameter int RST_HOLD   = DEF_RST_HOLD,
    parameter int SYNC_WAIT  = DEF_SYNC_WAIT,
    parameter int PLL_SETTLE = DEF_PLL_SETTLE,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_ext_clk_sel,
    input  logic [2:0] req_sel,
    input  logic [2:0] req_sel2,
    output logic       ext_clk_sel,
    output logic [2:0] sel,
    output logic [2:0] sel2,
    output logic       ext_reset,
    output logic       pll_ena,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(dwell_load(RST_HOLD));
    localparam logic [CNT_W-1:0] LD_SYNC   = CNT_W'(dwell_load(SYNC_WAIT));
    localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(dwell_load(PLL_SETTLE));

    state_t           state;
    logic             tgt_ext_clk_sel;
    logic [2:0]       tgt_sel;
    logic [2:0]       tgt_sel2;
    logic             accept;
    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_zero;

    assign accept = req_valid & req_ready;

    clock_config_sequencer_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    // Reload the dwell counter on every transition into a timed state.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    timer_load  = 1'b1;
                    timer_value = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (timer_zero) begin
                    timer_load  = 1'b1;
                    timer_value = LD_SYNC;
                end
            end
            ST_PARK: begin
                if (timer_zero) begin
                    timer_load  = 1'b1;
                    timer_value = tgt_ext_clk_sel ? LD_SYNC : LD_SETTLE;
                end
            end
            ST_PLLON, ST_APPLY: begin
                if (timer_zero) begin
                    timer_load  = 1'b1;
                    timer_value = LD_SYNC;
                end
            end
            default: ;
        endcase
    end

    // Sequencer FSM; dividers only move while the core is parked on the pad clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            ext_clk_sel     <= 1'b1;
            sel             <= 3'd0;
            sel2            <= 3'd0;
            ext_reset       <= 1'b0;
            pll_ena         <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            req_ready       <= 1'b1;
            tgt_ext_clk_sel <= 1'b1;
            tgt_sel         <= 3'd0;
            tgt_sel2        <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        tgt_ext_clk_sel <= req_ext_clk_sel;
                        tgt_sel         <= req_sel;
                        tgt_sel2        <= req_sel2;
                        ext_reset       <= 1'b1;
                        busy            <= 1'b1;
                        req_ready       <= 1'b0;
                        state           <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (timer_zero) begin
                        ext_clk_sel <= 1'b1;
                        state       <= ST_PARK;
                    end
                end
                ST_PARK: begin
                    if (timer_zero) begin
                        if (!tgt_ext_clk_sel) begin
                            pll_ena <= 1'b1;
                            state   <= ST_PLLON;
                        end else begin
                            pll_ena <= 1'b0;
                            sel     <= tgt_sel;
                            sel2    <= tgt_sel2;
                            state   <= ST_APPLY;
                        end
                    end
                end
                ST_PLLON: begin
                    if (timer_zero) begin
                        sel   <= tgt_sel;
                        sel2  <= tgt_sel2;
                        state <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (timer_zero) begin
                        ext_clk_sel <= tgt_ext_clk_sel;
                        state       <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (timer_zero) begin
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    ext_reset <= 1'b0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_config_sequencer.sv
// tb/tb_clock_config_sequencer.sv - self-checking bench for clock_config_sequencer
module tb_clock_config_sequencer;

    typedef struct {
        logic       ext;
        logic [2:0] sel;
        logic [2:0] sel2;
        logic       pll;
    } cfg_t;

    typedef struct {
        logic       ext_clk_sel;
        logic [2:0] sel;
        logic [2:0] sel2;
        logic       ext_reset;
        logic       pll_ena;
        logic       busy;
        logic       done;
        logic       req_ready;
    } exp_t;

    typedef struct {
        logic       ext;
        logic [2:0] sel;
        logic [2:0] sel2;
        int         exp_total;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, req_valid, req_ext_clk_sel;
    logic [2:0] req_sel, req_sel2;
    logic       req_ready, ext_clk_sel, ext_reset, pll_ena, busy, done;
    logic [2:0] sel, sel2;

    logic       f_reset, f_req_valid, f_req_ext_clk_sel;
    logic [2:0] f_req_sel, f_req_sel2;
    logic       f_req_ready, f_ext_clk_sel, f_ext_reset, f_pll_ena, f_busy, f_done;
    logic [2:0] f_sel, f_sel2;

    clock_config_sequencer #(
        .RST_HOLD(4), .SYNC_WAIT(8), .PLL_SETTLE(256), .CNT_W(16)
    ) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_ext_clk_sel(req_ext_clk_sel), .req_sel(req_sel), .req_sel2(req_sel2),
        .ext_clk_sel(ext_clk_sel), .sel(sel), .sel2(sel2), .ext_reset(ext_reset),
        .pll_ena(pll_ena), .busy(busy), .done(done)
    );

    clock_config_sequencer #(
        .RST_HOLD(0), .SYNC_WAIT(0), .PLL_SETTLE(0), .CNT_W(16)
    ) u_fast (
        .clk(clk), .reset(f_reset), .req_valid(f_req_valid), .req_ready(f_req_ready),
        .req_ext_clk_sel(f_req_ext_clk_sel), .req_sel(f_req_sel), .req_sel2(f_req_sel2),
        .ext_clk_sel(f_ext_clk_sel), .sel(f_sel), .sel2(f_sel2), .ext_reset(f_ext_reset),
        .pll_ena(f_pll_ena), .busy(f_busy), .done(f_done)
    );

    int         tests = 0;
    int         fails = 0;
    cfg_t       cur;
    logic       have_prev;
    logic       prev_ext;
    logic [2:0] prev_sel, prev_sel2;

    function automatic int mx1(input int n);
        return (n < 1) ? 1 : n;
    endfunction

    function automatic int seq_total(input int rh, input int sw, input int ps, input logic tgt_ext);
        return mx1(rh) + mx1(sw) + (tgt_ext ? 0 : mx1(ps)) + mx1(sw) + mx1(sw) + 1;
    endfunction

    // Output timeline, k cycles after the accepting edge, from the phase durations.
    function automatic exp_t model(input int rh, input int sw, input int ps,
                                   input cfg_t prev, input cfg_t tgt, input int k);
        exp_t e;
        int h, s, p, t_pll, t_apply, t_select, total;
        h        = mx1(rh);
        s        = mx1(sw);
        p        = tgt.ext ? 0 : mx1(ps);
        t_pll    = h + s;
        t_apply  = t_pll + p;
        t_select = t_apply + s;
        total    = t_select + s + 1;
        e.ext_reset   = (k < total);
        e.busy        = (k < total);
        e.req_ready   = !(k < total);
        e.done        = (k == total);
        e.ext_clk_sel = (k < h) ? prev.ext : ((k < t_select) ? 1'b1 : tgt.ext);
        e.pll_ena     = (k < t_pll) ? prev.pll : !tgt.ext;
        e.sel         = (k < t_apply) ? prev.sel : tgt.sel;
        e.sel2        = (k < t_apply) ? prev.sel2 : tgt.sel2;
        return e;
    endfunction

    function automatic exp_t idle_exp(input cfg_t c);
        exp_t e;
        e.ext_clk_sel = c.ext;
        e.sel         = c.sel;
        e.sel2        = c.sel2;
        e.pll_ena     = c.pll;
        e.ext_reset   = 1'b0;
        e.busy        = 1'b0;
        e.done        = 1'b0;
        e.req_ready   = 1'b1;
        return e;
    endfunction

    task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s k=%0d actual=%0h required=%0h", name, k, act, exp);
        end
    endtask

    task automatic check_main(input exp_t e, input string tag, input int k);
        cmp({tag, ".ext_clk_sel"}, k, 32'(ext_clk_sel), 32'(e.ext_clk_sel));
        cmp({tag, ".sel"},         k, 32'(sel),         32'(e.sel));
        cmp({tag, ".sel2"},        k, 32'(sel2),        32'(e.sel2));
        cmp({tag, ".ext_reset"},   k, 32'(ext_reset),   32'(e.ext_reset));
        cmp({tag, ".pll_ena"},     k, 32'(pll_ena),     32'(e.pll_ena));
        cmp({tag, ".busy"},        k, 32'(busy),        32'(e.busy));
        cmp({tag, ".done"},        k, 32'(done),        32'(e.done));
        cmp({tag, ".req_ready"},   k, 32'(req_ready),   32'(e.req_ready));
        if (have_prev && (sel !== prev_sel || sel2 !== prev_sel2))
            cmp({tag, ".div_change_on_pad_clk"}, k, 32'(ext_clk_sel & prev_ext), 32'd1);
        cmp({tag, ".ext_reset_eq_busy"}, k, 32'(ext_reset), 32'(busy));
        cmp({tag, ".ready_eq_not_busy"}, k, 32'(req_ready), 32'(!busy));
        prev_ext  = ext_clk_sel;
        prev_sel  = sel;
        prev_sel2 = sel2;
        have_prev = 1'b1;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_main(idle_exp(cur), tag, i);
        end
    endtask

    task automatic drive_req(input logic e, input logic [2:0] s, input logic [2:0] s2);
        req_valid       = 1'b1;
        req_ext_clk_sel = e;
        req_sel         = s;
        req_sel2        = s2;
    endtask

    // Called at the sample point right after the accepting edge (k=0).
    task automatic follow(input cfg_t tgt, input int exp_total, input string tag);
        int highs;
        int total;
        highs = 0;
        total = seq_total(4, 8, 256, tgt.ext);
        for (int k = 0; k <= total; k++) begin
            if (k > 0) @(negedge clk);
            check_main(model(4, 8, 256, cur, tgt, k), tag, k);
            if (ext_reset === 1'b1) highs++;
        end
        if (exp_total > 0) cmp({tag, ".reset_cycles"}, total, 32'(highs), 32'(exp_total));
        cur     = tgt;
        cur.pll = !tgt.ext;
    endtask

    vec_t vecs[5];
    cfg_t tgt, tgt_b, fcfg;
    exp_t fe;
    int   done_k;

    initial begin
        vecs[0] = '{1'b0, 3'd2, 3'd3, 285};
        vecs[1] = '{1'b1, 3'd0, 3'd0, 29};
        vecs[2] = '{1'b0, 3'd7, 3'd5, 285};
        vecs[3] = '{1'b0, 3'd1, 3'd4, 285};
        vecs[4] = '{1'b1, 3'd6, 3'd2, 29};

        reset = 1'b1; req_valid = 1'b0; req_ext_clk_sel = 1'b0; req_sel = 3'd0; req_sel2 = 3'd0;
        f_reset = 1'b1; f_req_valid = 1'b0; f_req_ext_clk_sel = 1'b0; f_req_sel = 3'd0; f_req_sel2 = 3'd0;
        have_prev = 1'b0; prev_ext = 1'b1; prev_sel = 3'd0; prev_sel2 = 3'd0;
        cur = '{1'b1, 3'd0, 3'd0, 1'b0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        f_reset = 1'b0;

        // Reset state held through idle cycles.
        idle_cycles(10, "t1_idle");

        // Table: PLL config, back to pad clock, further PLL and pad targets.
        for (int i = 0; i < 5; i++) begin
            tgt = '{vecs[i].ext, vecs[i].sel, vecs[i].sel2, 1'b0};
            drive_req(vecs[i].ext, vecs[i].sel, vecs[i].sel2);
            @(negedge clk);
            req_valid = 1'b0;
            follow(tgt, vecs[i].exp_total, $sformatf("vec%0d", i));
        end

        // Request held while busy with different fields is accepted only when ready returns.
        tgt   = '{1'b0, 3'd3, 3'd1, 1'b0};
        tgt_b = '{1'b1, 3'd5, 3'd6, 1'b0};
        drive_req(tgt.ext, tgt.sel, tgt.sel2);
        @(negedge clk);
        drive_req(tgt_b.ext, tgt_b.sel, tgt_b.sel2);
        follow(tgt, 285, "t4_first");
        @(negedge clk);
        req_valid = 1'b0;
        follow(tgt_b, 29, "t4_second");

        // Reset in the middle of PLLON, with a request present.
        tgt = '{1'b0, 3'd6, 3'd1, 1'b0};
        drive_req(tgt.ext, tgt.sel, tgt.sel2);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (k > 0) @(negedge clk);
            check_main(model(4, 8, 256, cur, tgt, k), "t5_pre", k);
        end
        reset = 1'b1;
        drive_req(1'b0, 3'd4, 3'd4);
        @(negedge clk);
        cur = '{1'b1, 3'd0, 3'd0, 1'b0};
        have_prev = 1'b0;
        check_main(idle_exp(cur), "t5_reset", 0);
        reset = 1'b0;
        req_valid = 1'b0;
        idle_cycles(5, "t5_post");

        // Reset beats a simultaneous request while idle.
        reset = 1'b1;
        drive_req(1'b0, 3'd2, 3'd2);
        @(negedge clk);
        check_main(idle_exp(cur), "t5_reset_wins", 0);
        reset = 1'b0;
        req_valid = 1'b0;
        idle_cycles(2, "t5_after");

        // Randomized requests with idle gaps.
        for (int i = 0; i < 12; i++) begin
            idle_cycles($urandom_range(0, 3), "rnd_gap");
            tgt.ext  = 1'($urandom_range(0, 1));
            tgt.sel  = 3'($urandom_range(0, 7));
            tgt.sel2 = 3'($urandom_range(0, 7));
            tgt.pll  = 1'b0;
            drive_req(tgt.ext, tgt.sel, tgt.sel2);
            @(negedge clk);
            req_valid = 1'b0;
            follow(tgt, -1, $sformatf("rnd%0d", i));
        end

        // All waits zero: each timed state lasts one cycle, done six cycles after accept.
        fcfg = '{1'b1, 3'd0, 3'd0, 1'b0};
        tgt  = '{1'b0, 3'd5, 3'd6, 1'b0};
        f_req_valid = 1'b1; f_req_ext_clk_sel = tgt.ext; f_req_sel = tgt.sel; f_req_sel2 = tgt.sel2;
        @(negedge clk);
        f_req_valid = 1'b0;
        done_k = -1;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(negedge clk);
            fe = model(0, 0, 0, fcfg, tgt, k);
            cmp("t6.ext_clk_sel", k, 32'(f_ext_clk_sel), 32'(fe.ext_clk_sel));
            cmp("t6.sel",         k, 32'(f_sel),         32'(fe.sel));
            cmp("t6.sel2",        k, 32'(f_sel2),        32'(fe.sel2));
            cmp("t6.pll_ena",     k, 32'(f_pll_ena),     32'(fe.pll_ena));
            cmp("t6.ext_reset",   k, 32'(f_ext_reset),   32'(fe.ext_reset));
            cmp("t6.busy",        k, 32'(f_busy),        32'(fe.busy));
            cmp("t6.done",        k, 32'(f_done),        32'(fe.done));
            cmp("t6.req_ready",   k, 32'(f_req_ready),   32'(fe.req_ready));
            if (f_done === 1'b1 && done_k < 0) done_k = k;
        end
        cmp("t6.done_latency", 0, 32'(done_k), 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
